alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
// Parametrised, registered successor to the 32-bit combinational datapath ALU. Keeps the same
// ALU control codes and flags, and adds iterative unsigned multiply and divide over a
// start/busy/done handshake. Sits between the register-file read ports and the
// writeback mux; the control unit stalls the pipeline while busy is high.
// PARAMETERS
// WIDTH   32  operand/result width in bits (>=4); iteration counter is $clog2(WIDTH)+1 bits
// MULDIV  1   1 = MULU/DIVU implemented; 0 = those codes are treated as illegal
// PORTS
// clk               in   1      rising-edge clock
// reset             in   1      asynchronous active-high reset
// start             in   1      request; sampled only when busy=0
// op1, op2          in   WIDTH  operands; captured on the accepting edge
// alu_control_code  in   4      operation select; captured on the accepting edge
// busy              out  1      multi-cycle operation in progress
// done              out  1      one-cycle pulse: result and flags updated this cycle
// result            out  WIDTH  primary result (MULU low half, DIVU quotient)
// result_hi         out  WIDTH  MULU high half, DIVU remainder; 0 for other operations
// v_flag,n_flag,z_flag out 1    overflow / negative / zero
// dbz_flag          out  1      DIVU with op2=0
// illegal_op        out  1      unsupported code was issued
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counter 0. Asynchronous reset mid-operation aborts the
//   operation, and no done is produced.
// - FSM: IDLE -(start, MULU/DIVU)-> ITER -(count==WIDTH-1)-> IDLE. All other codes stay in IDLE.
// - Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1001 NOR, 1100 NAND, 1101 XOR,
//   1111 NOP, 0011 MULU, 0100 DIVU. Any other code (and 0011/0100 when MULDIV=0) is illegal.
// - Single-cycle ops: start at edge E0 -> result, flags and done=1 visible after E0; done is low
//   after E1. busy stays 0.
// - MULU: shift-add, one bit per cycle. busy=1 for WIDTH cycles after E0. done=1 with the
//   2*WIDTH product in {result_hi,result} in cycle WIDTH+1. busy=0 in that cycle.
// - DIVU: restoring division, one bit per cycle, with the same timing as MULU.
//   quotient -> result, remainder -> result_hi.
// - DIVU with op2=0: same latency; result=all ones, result_hi=op1, dbz_flag=1.
// - start while busy=1 is ignored, with no queuing. start in the done cycle (busy=0) is accepted.
// - Flags update only on done:
//   - ADD: v = same operand signs and result sign differs; n = result[WIDTH-1].
//   - SUB: v = operand signs differ and result sign differs from op1; n = result[WIDTH-1].
//   - All other ops: v_flag and n_flag hold their previous value.
//   - z_flag = (result==0) on every done, including NOP.
//   - dbz_flag and illegal_op are cleared on every done except the one that sets them.
// - SLT is signed and correct on overflow: result = (op1-op2 negative) XOR (overflow) ? 1 : 0.
// - NOP: done pulses; result and result_hi hold; z_flag recomputed from the held result.
// - Illegal code: single cycle; done=1; result and result_hi hold; illegal_op=1.
// - Arithmetic wraps modulo 2^WIDTH. Outputs are stable between done pulses.
// TESTING (WIDTH=32)
// 1. ADD 0x7FFFFFFF+0x00000001 -> done after 1 edge; result=0x80000000, v=1, n=1, z=0, busy never high.
// 2. SUB 5-5 -> result=0, z=1, v=0, n=0. Then SLT 0xFFFFFFFF,0x00000001 -> result=1, v and n held.
// 3. MULU 0xFFFFFFFF*2 -> busy high 32 cycles; done in cycle 33; result=0xFFFFFFFE, result_hi=1.
// 4. DIVU 100/7 -> result=14, result_hi=2 at cycle 33. DIVU 9/0 -> result=0xFFFFFFFF,
//    result_hi=9, dbz_flag=1.
// 5. start ADD at cycle 5 during MULU -> ignored; MULU result intact. Back-to-back start in the
//    done cycle -> accepted.
// 6. reset at cycle 10 of DIVU -> busy=0 and all outputs 0 immediately; no done. Code 1010 ->
//    illegal_op=1 and result held.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arith ops and iterative
// unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_control_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             v_flag,
    output logic             n_flag,
    output logic             z_flag,
    output logic             dbz_flag,
    output logic             illegal_op
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Iteration registers: mul uses hi=partial product, lo=multiplier, b=multiplicand;
    // div uses hi=remainder, lo=dividend shifting into quotient, b=divisor.
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic             div_q, div_d, dbzp_q, dbzp_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             v_q, v_d, n_q, n_d, z_q, z_d, dbz_q, dbz_d, ill_q, ill_d;
    logic             done_q, done_d;

    // Single-cycle arithmetic on the live operands
    logic [WIDTH-1:0] sum, diff;
    logic             v_add, v_sub;
    // One multiply / divide step on the iteration registers
    logic [WIDTH:0]   add_w, rem_sh;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, rem_n, div_lo_n;
    logic             ge;
    // Decode scratch
    logic [WIDTH-1:0] r_n, rh_n;
    logic             ill_n, go;

    // Datapath for both single-cycle ops and one iterative step
    always_comb begin
        sum      = op1 + op2;
        diff     = op1 - op2;
        v_add    = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
        v_sub    = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
        add_w    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_n = add_w[WIDTH:1];
        mul_lo_n = {add_w[0], lo_q[WIDTH-1:1]};
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        ge       = rem_sh >= {1'b0, b_q};
        // With a zero divisor every step "subtracts" nothing, so the quotient
        // fills with ones and the remainder collects op1 -- exactly the dbz result.
        rem_n    = ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        div_lo_n = {lo_q[WIDTH-2:0], ge};
    end

    // Next-state, decode and output-register update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        b_d         = b_q;
        div_d       = div_q;
        dbzp_d      = dbzp_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        v_d         = v_q;
        n_d         = n_q;
        z_d         = z_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;
        done_d      = 1'b0;
        r_n         = result_q;
        rh_n        = result_hi_q;
        ill_n       = 1'b0;
        go          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (alu_control_code)
                        4'b0000: begin r_n = op1 & op2;    rh_n = '0; end
                        4'b0001: begin r_n = op1 | op2;    rh_n = '0; end
                        4'b1001: begin r_n = ~(op1 | op2); rh_n = '0; end
                        4'b1100: begin r_n = ~(op1 & op2); rh_n = '0; end
                        4'b1101: begin r_n = op1 ^ op2;    rh_n = '0; end
                        4'b0010: begin
                            r_n = sum; rh_n = '0; v_d = v_add; n_d = sum[WIDTH-1];
                        end
                        4'b0110: begin
                            r_n = diff; rh_n = '0; v_d = v_sub; n_d = diff[WIDTH-1];
                        end
                        4'b0111: begin
                            r_n  = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ v_sub};
                            rh_n = '0;
                        end
                        4'b1111: ;
                        4'b0011: begin
                            if (MULDIV) begin
                                go = 1'b1; div_d = 1'b0; dbzp_d = 1'b0;
                                hi_d = '0; lo_d = op2; b_d = op1;
                            end else begin
                                ill_n = 1'b1;
                            end
                        end
                        4'b0100: begin
                            if (MULDIV) begin
                                go = 1'b1; div_d = 1'b1; dbzp_d = (op2 == '0);
                                hi_d = '0; lo_d = op1; b_d = op2;
                            end else begin
                                ill_n = 1'b1;
                            end
                        end
                        default: ill_n = 1'b1;
                    endcase
                    if (go) begin
                        state_d = ITER;
                        cnt_d   = '0;
                    end else begin
                        done_d      = 1'b1;
                        result_d    = r_n;
                        result_hi_d = rh_n;
                        z_d         = (r_n == '0);
                        dbz_d       = 1'b0;
                        ill_d       = ill_n;
                    end
                end
            end
            ITER: begin
                hi_d  = div_q ? rem_n : mul_hi_n;
                lo_d  = div_q ? div_lo_n : mul_lo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    result_d    = lo_d;
                    result_hi_d = hi_d;
                    z_d         = (lo_d == '0);
                    dbz_d       = dbzp_q;
                    ill_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            div_q       <= 1'b0;
            dbzp_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            div_q       <= div_d;
            dbzp_q      <= dbzp_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            v_q         <= v_d;
            n_q         <= n_d;
            z_q         <= z_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
            done_q      <= done_d;
        end
    end

    assign busy       = (state_q == ITER);
    assign done       = done_q;
    assign result     = result_q;
    assign result_hi  = result_hi_q;
    assign v_flag     = v_q;
    assign n_flag     = n_q;
    assign z_flag     = z_q;
    assign dbz_flag   = dbz_q;
    assign illegal_op = ill_q;
endmodule
